// File: rtl/alu_pkg.sv
// Shared ALU boolean-unit types: function codes and the solver FSM state.
package alu_pkg;

  typedef logic [3:0] bfn_t;

  localparam bfn_t BFN_AND = 4'b1000;
  localparam bfn_t BFN_OR  = 4'b1110;
  localparam bfn_t BFN_XOR = 4'b0110;
  localparam bfn_t BFN_A   = 4'b1010;
  localparam bfn_t BFN_B   = 4'b1100;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

endpackage

// File: rtl/alu_bool_solve_if.sv
// Operand/result handshake bundle for the boolean-function solver.
interface alu_bool_solve_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  alu_pkg::bfn_t    bfn;
  alu_pkg::bfn_t    known;
  logic             conflict;

  modport master (
    output in_valid, a, b, y, out_ready,
    input  in_ready, out_valid, bfn, known, conflict
  );

  modport slave (
    input  in_valid, a, b, y, out_ready,
    output in_ready, out_valid, bfn, known, conflict
  );
endinterface

// File: rtl/alu_bool_merge.sv
// Combinational per-beat accumulator: folds LANES (a,b,y) bits into the
// running truth table, lowest lane first; first occurrence of an index wins.
module alu_bool_merge
  import alu_pkg::*;
#(
  parameter int LANES = 1
) (
  input  bfn_t             bfn_cur,
  input  bfn_t             known_cur,
  input  logic             conflict_cur,
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  input  logic [LANES-1:0] y,
  output bfn_t             bfn_nxt,
  output bfn_t             known_nxt,
  output logic             conflict_nxt
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    bfn_nxt      = bfn_cur;
    known_nxt    = known_cur;
    conflict_nxt = conflict_cur;
    // NOTE: blocking assignments here so each lane sees the updates made by the lanes below it.
    for (int i = 0; i < LANES; i++) begin
      if (!known_nxt[{b[i], a[i]}]) begin
        known_nxt[{b[i], a[i]}] = 1'b1;
        bfn_nxt[{b[i], a[i]}]   = y[i];
      end else if (bfn_nxt[{b[i], a[i]}] != y[i]) begin
        conflict_nxt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_bool_solve.sv
// Iterative inverse of the ALU boolean unit: recovers the 4-bit function code
// from (a, b, y), scanning LANES bits per cycle.
module alu_bool_solve
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_bool_solve_if.slave  bus
);

  localparam int BEATS = WIDTH / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             drain;
  logic [WIDTH-1:0] a_q, b_q, y_q;
  bfn_t             bfn_q, known_q;
  logic             conflict_q;
  bfn_t             bfn_m, known_m;
  logic             conflict_m;

  alu_bool_merge #(.LANES(LANES)) u_merge (
    .bfn_cur      (bfn_q),
    .known_cur    (known_q),
    .conflict_cur (conflict_q),
    .a            (a_q[LANES-1:0]),
    .b            (b_q[LANES-1:0]),
    .y            (y_q[LANES-1:0]),
    .bfn_nxt      (bfn_m),
    .known_nxt    (known_m),
    .conflict_nxt (conflict_m)
  );

  // After the final beat, one drain cycle in SCAN before results are offered.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  state_nxt = SCAN;
      SCAN:    if (drain)         state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      drain      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      y_q        <= '0;
      bfn_q      <= '0;
      known_q    <= '0;
      conflict_q <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            y_q        <= bus.y;
            bfn_q      <= '0;
            known_q    <= '0;
            conflict_q <= 1'b0;
            cnt        <= '0;
            drain      <= 1'b0;
          end
        end
        SCAN: begin
          if (!drain) begin
            bfn_q      <= bfn_m;
            known_q    <= known_m;
            conflict_q <= conflict_m;
            // Operands shift down so the current beat always sits in the low lanes.
            a_q        <= a_q >> LANES;
            b_q        <= b_q >> LANES;
            y_q        <= y_q >> LANES;
            if (cnt == LAST) drain <= 1'b1;
            else             cnt   <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.bfn       = bfn_q;
  assign bus.known     = known_q;
  assign bus.conflict  = conflict_q;

endmodule

// File: tb/tb_alu_bool_solve.sv
// Scoreboard bench for alu_bool_solve: LANES=1 and LANES=4 instances checked
// against a vector-arithmetic reference of the truth-table recovery.
module tb_alu_bool_solve;
  import alu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_bool_solve_if #(.WIDTH(W)) bus1 ();
  alu_bool_solve_if #(.WIDTH(W)) bus4 ();

  alu_bool_solve #(.WIDTH(W), .LANES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  alu_bool_solve #(.WIDTH(W), .LANES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  typedef struct {
    int   acc;
    bfn_t bfn;
    bfn_t known;
    logic conflict;
    bfn_t f;
    bit   use_f;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   seen[2];
  bit   rand_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Reference: for index k the set of bits with {b,a}==k is a mask; its
  // lowest set bit is the first occurrence, any differing y in it is a conflict.
  function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic [31:0] y);
    exp_t e;
    e = '{default: 0};
    for (int k = 0; k < 4; k++) begin
      logic [31:0] m, ka, kb, low;
      logic yf;
      ka = k[0] ? '1 : '0;
      kb = k[1] ? '1 : '0;
      m  = ~(a ^ ka) & ~(b ^ kb);
      if (m != 0) begin
        low = m & (~m + 32'd1);
        yf  = |(y & low);
        e.known[k] = 1'b1;
        e.bfn[k]   = yf;
        if ((m & (y ^ {32{yf}})) != 0) e.conflict = 1'b1;
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] alu_bool(logic [31:0] a, logic [31:0] b, bfn_t f);
    return ({32{f[0]}} & ~a & ~b) | ({32{f[1]}} & a & ~b) |
           ({32{f[2]}} & ~a & b)  | ({32{f[3]}} & a & b);
  endfunction

  function automatic logic rdy(int d);
    return (d == 0) ? bus1.in_ready : bus4.in_ready;
  endfunction

  function automatic int lat(int d);
    return (d == 0) ? W / 1 + 1 : W / 4 + 1;
  endfunction

  task automatic push(int d, int acc, bfn_t bf, bfn_t kn, logic cf, bfn_t f, bit use_f);
    exp_t e;
    e = '{acc: acc, bfn: bf, known: kn, conflict: cf, f: f, use_f: use_f};
    if (d == 0) q1.push_back(e);
    else        q4.push_back(e);
  endtask

  task automatic send(int d, logic [31:0] a, logic [31:0] b, logic [31:0] y, output int acc);
    int n;
    @(negedge clk);
    if (d == 0) begin
      bus1.in_valid = 1'b1; bus1.a = a; bus1.b = b; bus1.y = y;
    end else begin
      bus4.in_valid = 1'b1; bus4.a = a; bus4.b = b; bus4.y = y;
    end
    n = 0;
    while (!rdy(d) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy(d)) fail_now("accept_wait");
    @(posedge clk);
    @(negedge clk);
    if (d == 0) bus1.in_valid = 1'b0;
    else        bus4.in_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic mon(int d, logic ov, bfn_t bf, bfn_t kn, logic cf);
    exp_t e;
    bit   have;
    if (!ov) begin
      seen[d] = 0;
    end else if (!seen[d]) begin
      seen[d] = 1;
      have = 0;
      if (d == 0 && q1.size() > 0) begin e = q1.pop_front(); have = 1; end
      if (d == 1 && q4.size() > 0) begin e = q4.pop_front(); have = 1; end
      if (!have) begin
        fail_now(d == 0 ? "unexpected_out_valid_l1" : "unexpected_out_valid_l4");
      end else begin
        check(d == 0 ? "latency_l1" : "latency_l4", cyc - e.acc, lat(d));
        check(d == 0 ? "bfn_l1" : "bfn_l4", bf, e.bfn);
        check(d == 0 ? "known_l1" : "known_l4", kn, e.known);
        check(d == 0 ? "conflict_l1" : "conflict_l4", cf, e.conflict);
        if (e.use_f) check("bfn_vs_f_l4", bf & kn, e.f & kn);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus1.out_valid, bus1.bfn, bus1.known, bus1.conflict);
    mon(1, bus4.out_valid, bus4.bfn, bus4.known, bus4.conflict);
  end

  task automatic wait_empty(string name);
    int n;
    n = 0;
    while ((q1.size() > 0 || q4.size() > 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (q1.size() > 0 || q4.size() > 0) fail_now(name);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc, hs, n;
    exp_t e;
    bfn_t codes[4];
    logic [31:0] ra, rb, ry;
    bfn_t rf;

    codes = '{BFN_OR, BFN_XOR, BFN_A, BFN_B};
    bus1.in_valid = 0; bus1.a = 0; bus1.b = 0; bus1.y = 0; bus1.out_ready = 1;
    bus4.in_valid = 0; bus4.a = 0; bus4.b = 0; bus4.y = 0; bus4.out_ready = 1;

    repeat (3) @(negedge clk);
    check("rst_in_ready", bus1.in_ready, 1);
    check("rst_out_valid", bus1.out_valid, 0);
    check("rst_bfn", bus1.bfn, 0);
    check("rst_known", bus1.known, 0);
    check("rst_conflict", bus1.conflict, 0);
    check("rst_in_ready_l4", bus4.in_ready, 1);
    rst_n = 1'b1;

    // Directed jobs on LANES=1.
    send(0, 32'hFFFF0000, 32'hFF00FF00, 32'hFF000000, acc);
    push(0, acc, BFN_AND, 4'b1111, 0, 0, 0);
    send(0, 32'h0, 32'h0, 32'h0, acc);
    push(0, acc, 4'b0000, 4'b0001, 0, 0, 0);
    send(0, 32'h0, 32'h0, 32'hFFFFFFFF, acc);
    push(0, acc, 4'b0001, 4'b0001, 0, 0, 0);
    send(0, 32'h0, 32'h0, 32'h00000001, acc);
    push(0, acc, 4'b0001, 4'b0001, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      send(0, 32'hFFFF0000, 32'hFF00FF00, alu_bool(32'hFFFF0000, 32'hFF00FF00, codes[i]), acc);
      push(0, acc, codes[i], 4'b1111, 0, 0, 0);
    end
    wait_empty("drain_directed");

    // Backpressure in DONE, then back-to-back job.
    bus1.out_ready = 1'b0;
    send(0, 32'hFFFF0000, 32'hFF00FF00, alu_bool(32'hFFFF0000, 32'hFF00FF00, BFN_OR), acc);
    push(0, acc, BFN_OR, 4'b1111, 0, 0, 0);
    n = 0;
    while (!bus1.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus1.out_valid) fail_now("bp_wait_done");
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", bus1.out_valid, 1);
      check("bp_in_ready", bus1.in_ready, 0);
      check("bp_bfn", bus1.bfn, BFN_OR);
      check("bp_known", bus1.known, 4'b1111);
      check("bp_conflict", bus1.conflict, 0);
      @(negedge clk);
    end
    bus1.out_ready = 1'b1;
    bus1.in_valid = 1'b1;
    bus1.a = 32'hFFFF0000; bus1.b = 32'hFF00FF00; bus1.y = 32'hFF000000;
    @(posedge clk);
    @(negedge clk);
    hs = cyc;
    check("hs_in_ready", bus1.in_ready, 1);
    check("hs_out_valid", bus1.out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    acc = cyc;
    check("b2b_accept_edge", acc - hs, 1);
    check("b2b_in_ready", bus1.in_ready, 0);
    push(0, acc, BFN_AND, 4'b1111, 0, 0, 0);
    wait_empty("drain_bp");

    // Reset mid-scan: no result may appear for the aborted job.
    send(0, 32'h0, 32'h0, 32'hFFFFFFFF, acc);
    repeat (9) @(negedge clk);
    check("mid_scan_known", bus1.known, 4'b0001);
    rst_n = 1'b0;
    #1;
    check("rst_mid_in_ready", bus1.in_ready, 1);
    check("rst_mid_out_valid", bus1.out_valid, 0);
    check("rst_mid_bfn", bus1.bfn, 0);
    check("rst_mid_known", bus1.known, 0);
    check("rst_mid_conflict", bus1.conflict, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("post_rst_in_ready", bus1.in_ready, 1);
    repeat (40) @(negedge clk);
    send(0, 32'hFFFF0000, 32'hFF00FF00, 32'hFF000000, acc);
    push(0, acc, BFN_AND, 4'b1111, 0, 0, 0);
    wait_empty("drain_reset");

    // Randomized: LANES=4 with y from a random function, LANES=1 with raw y.
    fork
      begin
        for (int j = 0; j < 1000; j++) begin
          ra = $urandom;
          rb = $urandom;
          rf = bfn_t'($urandom_range(0, 15));
          ry = alu_bool(ra, rb, rf);
          send(1, ra, rb, ry, acc);
          e = model(ra, rb, ry);
          push(1, acc, e.bfn, e.known, 0, rf, 1);
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          bus4.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus4.out_ready = 1'b1;
      end
      begin
        for (int j = 0; j < 20; j++) begin
          logic [31:0] xa, xb, xy;
          int acc1;
          exp_t e1;
          xa = $urandom;
          xb = ($urandom_range(0, 2) == 0) ? xa : $urandom;
          xy = $urandom;
          send(0, xa, xb, xy, acc1);
          e1 = model(xa, xb, xy);
          push(0, acc1, e1.bfn, e1.known, e1.conflict, 0, 0);
        end
      end
    join
    wait_empty("drain_random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
